// File: rtl/keynsham_fetch_pkg.sv
// Shared types for the keynsham instruction fetch unit: FSM encoding, buffer depth, buffer entry.
package keynsham_fetch_pkg;

    localparam int FETCH_DEPTH = 2;
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
    localparam int PC_W        = 30;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISCARD,
        ST_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/keynsham_fetch_fifo.sv
// Two-entry {instr, pc} buffer with synchronous flush; head is read straight from storage.
// A push into a full buffer is accepted only together with a pop.
module keynsham_fetch_fifo
    import keynsham_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t mem [FETCH_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(FETCH_DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Single-bit pointers: with two entries, advancing is a toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/keynsham_fetch.sv
// Instruction fetch: one outstanding bus request feeding a 2-entry buffer; one word per 2 cycles best case.
// Optional bus timeout fault under KEYNSHAM_FETCH_TIMEOUT_EN; otherwise waits indefinitely for ack.
module keynsham_fetch
    import keynsham_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = 30'h0,
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               i_access,
    output logic [PC_W-1:0]    i_addr,
    input  logic [INSTR_W-1:0] i_data,
    input  logic               i_ack,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               fault
);

    fetch_state_t     state;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  req_addr;
    logic             pending;
    logic             push;
    logic             pop;
    logic             continue_fetch;
    logic [CNT_W:0]   occ_after;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;

    assign pending     = (state == ST_FETCH) || (state == ST_DISCARD);
    assign i_access    = pending && !i_ack;
    assign i_addr      = req_addr;
    assign instr_valid = (count != '0);
    assign push        = (state == ST_FETCH) && i_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

    // Occupancy once this cycle's ack push and consumer pop have landed.
    assign occ_after      = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    assign continue_fetch = (occ_after < (CNT_W+1)'(FETCH_DEPTH));

    keynsham_fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ('{instr: i_data, pc: req_addr}),
        .dout  (head),
        .count (count)
    );

`ifdef KEYNSHAM_FETCH_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             fault_q;

    assign tmo_hit = (state == ST_FETCH) && !i_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign fault   = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state != ST_FETCH) || i_ack) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign fault              = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
`ifdef KEYNSHAM_FETCH_TIMEOUT_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        req_addr <= redirect_pc;
                        state    <= ST_FETCH;
                    end else if (count < CNT_W'(FETCH_DEPTH)) begin
                        req_addr <= fetch_pc;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (i_ack) begin
                            req_addr <= redirect_pc;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (i_ack) begin
                        fetch_pc <= fetch_pc + 30'd1;
                        if (continue_fetch) begin
                            req_addr <= fetch_pc + 30'd1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
`ifdef KEYNSHAM_FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        fault_q <= 1'b1;
                        state   <= ST_FAULT;
                    end
`endif
                end
                ST_DISCARD: begin
                    if (redirect) fetch_pc <= redirect_pc;
                    if (i_ack)    state    <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        req_addr <= redirect_pc;
                        state    <= ST_FETCH;
`ifdef KEYNSHAM_FETCH_TIMEOUT_EN
                        fault_q  <= 1'b0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
